// File: rtl/b_io_l3_in_serialize_b_m_axi_wr_issuer.sv
// Write-command issuer for the B-port m_axi channel: one AW per command, zero-latency W pass-through.
// Optional B_IO_L3_WR_ISSUER_STATS_EN adds a saturating stall_cnt output.
module b_io_l3_in_serialize_b_m_axi_wr_issuer #(
  parameter int unsigned BUS_ADDR_WIDTH  = 32,
  parameter int unsigned BUS_DATA_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        ACLK_EN,
  input  logic [BUS_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]        cmd_len,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [BUS_DATA_WIDTH-1:0]   s_wdata,
  input  logic [BUS_DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                        s_wvalid,
  output logic                        s_wready,
  output logic [BUS_ADDR_WIDTH-1:0]   out_HLS_AWADDR,
  output logic [31:0]                 out_HLS_AWLEN,
  output logic                        out_HLS_AWVALID,
  input  logic                        in_HLS_AWREADY,
  output logic [BUS_DATA_WIDTH-1:0]   out_HLS_WDATA,
  output logic [BUS_DATA_WIDTH/8-1:0] out_HLS_WSTRB,
  output logic                        out_HLS_WVALID,
  input  logic                        in_HLS_WREADY,
  input  logic                        in_HLS_BVALID,
  output logic                        out_HLS_BREADY,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        done_cnt
`ifdef B_IO_L3_WR_ISSUER_STATS_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StData} state_e;

  state_e                    state_q, state_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]      len_q, len_d;
  logic [CNT_WIDTH-1:0]      beats_q, beats_d;
  logic [OUT_W-1:0]          outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]      done_q, done_d;
  logic                      aw_hs, w_hs, b_dec;

  assign out_HLS_AWADDR = addr_q;
  assign out_HLS_AWLEN  = 32'(len_q - CNT_WIDTH'(1));
  assign out_HLS_WDATA  = s_wdata;
  assign out_HLS_WSTRB  = s_wstrb;
  assign out_HLS_BREADY = 1'b1;
  assign busy           = (state_q != StIdle) || (outstanding_q != '0);
  assign done_cnt       = done_q;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beats_d         = beats_q;
    cmd_ready       = 1'b0;
    out_HLS_AWVALID = 1'b0;
    out_HLS_WVALID  = 1'b0;
    s_wready        = 1'b0;
    aw_hs           = 1'b0;
    w_hs            = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Held low while reset is asserted so the reset-value view holds in that cycle.
        cmd_ready = !ARESET;
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          beats_d = cmd_len;
          if (cmd_len != '0) state_d = StIssue;
        end
      end
      StIssue: begin
        // Outstanding can only fall while waiting here, so AWVALID never drops once raised.
        out_HLS_AWVALID = (outstanding_q < MAX_OUT);
        if (out_HLS_AWVALID && in_HLS_AWREADY) begin
          aw_hs   = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        out_HLS_WVALID = s_wvalid;
        s_wready       = in_HLS_WREADY;
        if (s_wvalid && in_HLS_WREADY) begin
          w_hs    = 1'b1;
          beats_d = beats_q - CNT_WIDTH'(1);
          if (beats_q == CNT_WIDTH'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Responses arriving with nothing outstanding are counted as done but not subtracted.
  assign b_dec = in_HLS_BVALID && (outstanding_q != '0);

  always_comb begin
    outstanding_d = outstanding_q;
    if (aw_hs && !b_dec)      outstanding_d = outstanding_q + OUT_W'(1);
    else if (!aw_hs && b_dec) outstanding_d = outstanding_q - OUT_W'(1);
    done_d = in_HLS_BVALID ? done_q + CNT_WIDTH'(1) : done_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      len_q         <= '0;
      beats_q       <= '0;
      outstanding_q <= '0;
      done_q        <= '0;
    end else if (ACLK_EN) begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      beats_q       <= beats_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

`ifdef B_IO_L3_WR_ISSUER_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_ev;

  assign stall_ev = ((state_q == StIssue) && !out_HLS_AWVALID) ||
                    ((state_q == StData) && s_wvalid && !in_HLS_WREADY);

  always_comb begin
    stall_d = stall_q;
    if (stall_ev && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)       stall_q <= '0;
    else if (ACLK_EN) stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_b_io_l3_in_serialize_b_m_axi_wr_issuer.sv
// Randomized bench for the B-port write issuer, checked against a transaction-level model.
module tb_b_io_l3_in_serialize_b_m_axi_wr_issuer;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXO = 2;
  localparam int unsigned CW   = 32;

  logic            ACLK = 1'b0;
  logic            ARESET, ACLK_EN;
  logic [AW-1:0]   cmd_addr;
  logic [CW-1:0]   cmd_len;
  logic            cmd_valid, cmd_ready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid, s_wready;
  logic [AW-1:0]   out_HLS_AWADDR;
  logic [31:0]     out_HLS_AWLEN;
  logic            out_HLS_AWVALID, in_HLS_AWREADY;
  logic [DW-1:0]   out_HLS_WDATA;
  logic [DW/8-1:0] out_HLS_WSTRB;
  logic            out_HLS_WVALID, in_HLS_WREADY;
  logic            in_HLS_BVALID, out_HLS_BREADY;
  logic            busy;
  logic [CW-1:0]   done_cnt;
`ifdef B_IO_L3_WR_ISSUER_STATS_EN
  logic [31:0]     stall_cnt;
`endif

  b_io_l3_in_serialize_b_m_axi_wr_issuer #(
    .BUS_ADDR_WIDTH (AW),
    .BUS_DATA_WIDTH (DW),
    .MAX_OUTSTANDING(MAXO),
    .CNT_WIDTH      (CW)
  ) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .ACLK_EN        (ACLK_EN),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .s_wdata        (s_wdata),
    .s_wstrb        (s_wstrb),
    .s_wvalid       (s_wvalid),
    .s_wready       (s_wready),
    .out_HLS_AWADDR (out_HLS_AWADDR),
    .out_HLS_AWLEN  (out_HLS_AWLEN),
    .out_HLS_AWVALID(out_HLS_AWVALID),
    .in_HLS_AWREADY (in_HLS_AWREADY),
    .out_HLS_WDATA  (out_HLS_WDATA),
    .out_HLS_WSTRB  (out_HLS_WSTRB),
    .out_HLS_WVALID (out_HLS_WVALID),
    .in_HLS_WREADY  (in_HLS_WREADY),
    .in_HLS_BVALID  (in_HLS_BVALID),
    .out_HLS_BREADY (out_HLS_BREADY),
    .busy           (busy),
    .done_cnt       (done_cnt)
`ifdef B_IO_L3_WR_ISSUER_STATS_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level model: one active command, its AW status, beats left, outstanding responses.
  bit          m_active;
  bit          m_aw_done;
  logic [31:0] m_addr;
  logic [31:0] m_len;
  int          m_left;
  int          m_out;
  logic [31:0] m_done;
  logic [31:0] m_stall;
  int          n_aw;
  int          n_w;

  task automatic model_reset();
    m_active  = 1'b0;
    m_aw_done = 1'b0;
    m_addr    = '0;
    m_len     = '0;
    m_left    = 0;
    m_out     = 0;
    m_done    = '0;
    m_stall   = '0;
  endtask

  task automatic drive_random();
    ACLK_EN        = ($urandom_range(0, 9) != 0);
    cmd_valid      = ($urandom_range(0, 1) == 1);
    cmd_addr       = $urandom & 32'hFFFF_FFFC;
    cmd_len        = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 6));
    s_wvalid       = ($urandom_range(0, 9) < 7);
    s_wdata        = $urandom;
    s_wstrb        = 4'($urandom);
    in_HLS_AWREADY = ($urandom_range(0, 9) < 6);
    in_HLS_WREADY  = ($urandom_range(0, 9) < 7);
    in_HLS_BVALID  = (m_out > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
  endtask

  task automatic cycle_random();
    bit exp_aw, exp_data, cmd_hs, aw_hs, w_hs, b_dec;
    @(negedge ACLK);
    drive_random();
    #1;
    exp_aw   = m_active && !m_aw_done && (m_out < int'(MAXO));
    exp_data = m_active && m_aw_done;
    check_eq("cmd_ready", 64'(cmd_ready), 64'(!m_active));
    check_eq("awvalid", 64'(out_HLS_AWVALID), 64'(exp_aw));
    check_eq("s_wready", 64'(s_wready), 64'(exp_data && in_HLS_WREADY));
    check_eq("wvalid", 64'(out_HLS_WVALID), 64'(exp_data && s_wvalid));
    check_eq("bready", 64'(out_HLS_BREADY), 64'(1));
    cmd_hs = cmd_valid && !m_active;
    aw_hs  = exp_aw && in_HLS_AWREADY;
    w_hs   = exp_data && s_wvalid && in_HLS_WREADY;
    if (exp_aw) begin
      check_eq("awaddr", 64'(out_HLS_AWADDR), 64'(m_addr));
      check_eq("awlen", 64'(out_HLS_AWLEN), 64'(m_len - 32'd1));
    end
    if (w_hs) begin
      check_eq("wdata", 64'(out_HLS_WDATA), 64'(s_wdata));
      check_eq("wstrb", 64'(out_HLS_WSTRB), 64'(s_wstrb));
    end
    @(posedge ACLK);
    if (ACLK_EN) begin
      if ((!exp_aw && m_active && !m_aw_done) || (exp_data && s_wvalid && !in_HLS_WREADY))
        m_stall++;
      b_dec = in_HLS_BVALID && (m_out > 0);
      if (in_HLS_BVALID) m_done++;
      if (cmd_hs && cmd_len != '0) begin
        m_active  = 1'b1;
        m_aw_done = 1'b0;
        m_addr    = cmd_addr;
        m_len     = cmd_len;
        m_left    = int'(cmd_len);
      end
      if (aw_hs) begin
        m_aw_done = 1'b1;
        n_aw++;
      end
      if (w_hs) begin
        n_w++;
        m_left--;
        if (m_left == 0) m_active = 1'b0;
      end
      m_out = m_out + (aw_hs ? 1 : 0) - (b_dec ? 1 : 0);
    end
    #1;
    check_eq("busy", 64'(busy), 64'(m_active || m_out != 0));
    check_eq("done_cnt", 64'(done_cnt), 64'(m_done));
`ifdef B_IO_L3_WR_ISSUER_STATS_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
    check_eq({tag, "_awvalid"}, 64'(out_HLS_AWVALID), 64'(0));
    check_eq({tag, "_wvalid"}, 64'(out_HLS_WVALID), 64'(0));
    check_eq({tag, "_s_wready"}, 64'(s_wready), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'(0));
  endtask

  initial begin
    bit reached;
    n_aw = 0;
    n_w  = 0;
    ARESET = 1'b1;
    ACLK_EN = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    s_wvalid = 1'b0;
    s_wdata = '0;
    s_wstrb = '0;
    in_HLS_AWREADY = 1'b0;
    in_HLS_WREADY = 1'b0;
    in_HLS_BVALID = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    for (int i = 0; i < 1500; i++) cycle_random();

    // Abort a burst mid-data with reset and confirm everything returns to reset values at once.
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      cycle_random();
      reached = m_active && m_aw_done && (m_left < int'(m_len));
    end
    check_eq("reach_mid_burst", 64'(reached), 64'(1));
    @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();

    for (int i = 0; i < 800; i++) cycle_random();

    check_eq("aw_seen", 64'(n_aw > 50), 64'(1));
    check_eq("w_seen", 64'(n_w > 100), 64'(1));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
